rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage and valid/ready handshakes on every side. It generalises the fixed 2/3/4-input 32-bit muxes into a sequential block. Its first use is sharing one memory-side port between the I-cache and D-cache miss paths, and it also serves any N-to-1 request funnel in the core. It supports round-robin or fixed-priority arbitration, selected at run time.

Parameters:
WIDTH, 32, data bits per channel.
NUM_CH, 4, number of input channels (legal range 1..16).
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-index width (derived; must not be overridden).

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
prio_mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
req_valid_i  in  NUM_CH  per-channel request valid.
req_data_i  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
req_ready_o  out  NUM_CH  per-channel accept; at most one bit high per cycle.
out_valid_o  out  1  output stage holds a valid word.
out_data_o  out  WIDTH  registered data of the winning channel.
out_ch_o  out  CH_W  index of the channel that produced out_data_o.
out_ready_i  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid_o=0, out_data_o=0, out_ch_o=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_o=0 while rst_n_i low.
- Stage-can-load: load_en = !out_valid_o || out_ready_i. This is a full-throughput pipeline register. One word per cycle is sustained when out_ready_i is held high.
- Arbitration is combinational each cycle over req_valid_i:
  - Fixed mode: the winner is the lowest index k with req_valid_i[k]=1.
  - Round-robin mode: the winner is the first valid channel found scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH.
  - No valid request means no winner.
- req_ready_o[winner] = load_en; all other bits are 0. A transfer on channel k occurs when req_valid_i[k] && req_ready_o[k] at a rising edge.
- On a transfer:
  - out_data_o <= req_data_i[winner]; out_ch_o <= winner; out_valid_o <= 1.
  - Latency is 1 cycle from accept to out_valid_o.
- On load_en with no winner: out_valid_o <= 0. out_data_o and out_ch_o hold their values (don't-care while invalid).
- While out_valid_o && !out_ready_i:
  - The stage holds; out_data_o and out_ch_o are stable.
  - All req_ready_o are 0.
- rr_ptr update:
  - Only on a transfer, and only in round-robin mode: rr_ptr <= winner+1, wrapping from NUM_CH-1 to 0.
  - In fixed mode rr_ptr holds.
  - A mode switch takes effect the same cycle; the pointer is not reset.
- Requesters must hold req_valid_i and data until accepted. The arbiter may move its grant while a request is pending. There is no lock-on; the grant is re-evaluated every cycle.
- Simultaneous pop and push (out_valid_o && out_ready_i && winner exists): the new word replaces the old one in the same edge with no bubble.
- NUM_CH=1: out_ch_o is always 0 and rr_ptr is constant 0. The block degenerates to a one-entry pipeline register.
- Reset mid-transfer: an in-flight word is dropped. No req_ready_o is asserted until after reset release.
- All outputs are driven from registers except req_ready_o, which is combinational from req_valid_i, out_valid_o, out_ready_i, prio_mode_i and rr_ptr.

Test Plan:
1. Reset, then channel 2 requests with data 0xDEADBEEF and out_ready_i=1.
   - req_ready_o=4'b0100 in the same cycle.
   - Next cycle: out_valid_o=1, out_data_o=0xDEADBEEF, out_ch_o=2.
2. Round-robin, all 4 channels continuously valid (data 0x10,0x11,0x12,0x13), out_ready_i=1.
   - out_ch_o sequence is 0,1,2,3,0,1… and out_data_o tracks it.
   - One word per cycle, no bubbles.
3. Same stimulus as 2 with prio_mode_i=1.
   - out_ch_o stays 0 every cycle; channels 1–3 never see req_ready_o.
   - Deassert channel 0: the grant moves to 1 on the next cycle.
4. Backpressure: load word 0xA5A5A5A5 from channel 1, then hold out_ready_i=0 for 3 cycles while channel 3 is valid.
   - out_data_o is stable at 0xA5A5A5A5 and req_ready_o=0.
   - On out_ready_i=1, channel 3 is accepted in that same cycle and appears the next cycle.
5. Wrap-around: set rr_ptr to 3 via a transfer on channel 2, then request on channels 0 and 3 together.
   - Channel 3 wins first, then channel 0 on the following transfer.
6. Assert rst_n_i low asynchronously mid-stream with out_valid_o=1.
   - out_valid_o=0, out_data_o=0 and out_ch_o=0 immediately, without waiting for a clock edge.
   - After release, arbitration restarts from channel 0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux with a registered valid/ready output stage.
// Round-robin or fixed-priority arbitration, selectable at run time.
module rr_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    prio_mode_i,
    input  logic [NUM_CH-1:0]       req_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] req_data_i,
    output logic [NUM_CH-1:0]       req_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [CH_W-1:0]         out_ch_o,
    input  logic                    out_ready_i
);

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] winner;
    logic            found;
    logic            load_en;
    logic            xfer;

    assign load_en = !out_valid_o || out_ready_i;

    // Scan start is rr_ptr in round-robin mode, channel 0 in fixed mode.
    always_comb begin
        int start;
        int j;
        winner = '0;
        found  = 1'b0;
        start  = prio_mode_i ? 0 : int'(rr_ptr);
        for (int i = 0; i < NUM_CH; i++) begin
            j = start + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req_valid_i[j]) begin
                found  = 1'b1;
                winner = CH_W'(j);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (found && load_en && rst_n_i)
            req_ready_o[winner] = 1'b1;
    end

    assign xfer = found && load_en;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
        end else if (load_en) begin
            out_valid_o <= found;
            if (found) begin
                out_data_o <= req_data_i[winner*WIDTH +: WIDTH];
                out_ch_o   <= winner;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr <= '0;
        end else if (xfer && !prio_mode_i) begin
            if (winner == CH_W'(NUM_CH - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= winner + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux (4 channels, 32-bit).
// Immediate assertions at every comparison point.
module tb_rr_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           prio_mode_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
    logic [1:0]     out_ch_o;
    logic           out_ready_i;

    int checks   = 0;
    int failures = 0;

    rr_arb_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .prio_mode_i (prio_mode_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ch,
                           input logic [31:0] d);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_ch"}, 64'(out_ch_o), 64'(ch));
        chk({tag, "_data"}, 64'(out_data_o), 64'(d));
    endtask

    task automatic set_data(input int k, input logic [31:0] d);
        req_data_i[k*W +: W] = d;
    endtask

    initial begin
        int seq[6];
        seq = '{3, 0, 1, 2, 3, 0};

        rst_n_i     = 1'b0;
        prio_mode_i = 1'b0;
        req_valid_i = 4'b0100;
        req_data_i  = '0;
        out_ready_i = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", 64'(out_data_o), 64'd0);
        chk("rst_ch", 64'(out_ch_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        step();
        rst_n_i = 1'b1;

        // 1: single request on channel 2
        set_data(2, 32'hDEADBEEF);
        #1;
        chk("t1_ready", 64'(req_ready_o), 64'b0100);
        step();
        chk_out("t1_out", 2'd2, 32'hDEADBEEF);
        req_valid_i = 4'b0000;
        step();
        chk("t1_bubble", 64'(out_valid_o), 64'd0);

        // 2: round-robin, all valid; rr_ptr is 3 after test 1
        for (int k = 0; k < N; k++) set_data(k, 32'h10 + k);
        req_valid_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_ready", 64'(req_ready_o), 64'(4'b0001 << seq[i]));
            step();
            chk_out("t2_out", 2'(seq[i]), 32'h10 + seq[i]);
        end

        // 3: fixed priority
        prio_mode_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_ready", 64'(req_ready_o), 64'b0001);
            step();
            chk_out("t3_out", 2'd0, 32'h10);
        end
        req_valid_i = 4'b1110;
        #1;
        chk("t3_ready1", 64'(req_ready_o), 64'b0010);
        step();
        chk_out("t3_out1", 2'd1, 32'h11);

        // 4: backpressure; rr_ptr held at 1 through fixed mode
        prio_mode_i = 1'b0;
        set_data(1, 32'hA5A5A5A5);
        req_valid_i = 4'b0010;
        #1;
        chk("t4_ready1", 64'(req_ready_o), 64'b0010);
        step();
        chk_out("t4_load", 2'd1, 32'hA5A5A5A5);
        out_ready_i = 1'b0;
        set_data(3, 32'h33);
        req_valid_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_ready", 64'(req_ready_o), 64'd0);
            step();
            chk_out("t4_hold", 2'd1, 32'hA5A5A5A5);
        end
        out_ready_i = 1'b1;
        #1;
        chk("t4_ready3", 64'(req_ready_o), 64'b1000);
        step();
        chk_out("t4_out3", 2'd3, 32'h33);

        // 5: wrap-around
        set_data(2, 32'h22);
        req_valid_i = 4'b0100;
        #1;
        chk("t5_ready2", 64'(req_ready_o), 64'b0100);
        step();
        chk_out("t5_out2", 2'd2, 32'h22);
        set_data(0, 32'h20);
        req_valid_i = 4'b1001;
        #1;
        chk("t5_ready3", 64'(req_ready_o), 64'b1000);
        step();
        chk_out("t5_out3", 2'd3, 32'h33);
        #1;
        chk("t5_ready0", 64'(req_ready_o), 64'b0001);
        step();
        chk_out("t5_out0", 2'd0, 32'h20);

        // 6: asynchronous reset mid-stream
        for (int k = 0; k < N; k++) set_data(k, 32'h10 + k);
        req_valid_i = 4'b1110;
        step();
        chk_out("t6_pre", 2'd1, 32'h11);
        req_valid_i = 4'b1111;
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid_o), 64'd0);
        chk("t6_data", 64'(out_data_o), 64'd0);
        chk("t6_ch", 64'(out_ch_o), 64'd0);
        chk("t6_ready", 64'(req_ready_o), 64'd0);
        #1;
        rst_n_i = 1'b1;
        #1;
        chk("t6_ready_rel", 64'(req_ready_o), 64'b0001);
        step();
        chk_out("t6_out", 2'd0, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
